// File: rtl/f0_pulse_meter.sv
// f0_pulse_meter: measures high time and period of the f0 pulse train in clk cycles
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   f0           asynchronous pulse input (double-synchronized internally)
//   en           measurement enable; dropping it returns to IDLE
//   high_cnt     cycles f0 was high in the last complete period
//   period_cnt   cycles between the last two f0 rising edges
//   meas_valid   one-cycle strobe when high_cnt/period_cnt update
//   timeout      sticky flag: no rising edge within MAX_PERIOD cycles
//   locked       LOCK_N consecutive valid measurements seen
module f0_pulse_meter #(
    parameter int CNT_W      = 20,
    parameter int MAX_PERIOD = 100000,
    parameter int LOCK_N     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f0,
    input  logic             en,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             timeout,
    output logic             locked
);
    localparam int LW = $clog2(LOCK_N + 1);

    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

    state_t           state, state_nx;
    logic             s0, s1, d;
    logic             rise, fall, at_max;
    logic [CNT_W-1:0] cnt, cnt_nx, hcap, hcap_nx, high_nx, period_nx;
    logic [LW-1:0]    lock_cnt, lock_nx;
    logic             mv_nx, to_nx;

    assign rise   = s1 & ~d;
    assign fall   = ~s1 & d;
    assign at_max = cnt == CNT_W'(MAX_PERIOD - 1);
    assign locked = lock_cnt == LW'(LOCK_N);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0         <= 1'b0;
            s1         <= 1'b0;
            d          <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            hcap       <= '0;
            high_cnt   <= '0;
            period_cnt <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            lock_cnt   <= '0;
        end else begin
            s0         <= f0;
            s1         <= s0;
            d          <= s1;
            state      <= state_nx;
            cnt        <= cnt_nx;
            hcap       <= hcap_nx;
            high_cnt   <= high_nx;
            period_cnt <= period_nx;
            meas_valid <= mv_nx;
            timeout    <= to_nx;
            lock_cnt   <= lock_nx;
        end
    end

    // Rise is tested before the timeout limit so an edge landing exactly on
    // the limit still yields a valid measurement.
    always_comb begin
        state_nx  = state;
        cnt_nx    = (cnt == CNT_W'(MAX_PERIOD)) ? cnt : cnt + CNT_W'(1);
        hcap_nx   = hcap;
        high_nx   = high_cnt;
        period_nx = period_cnt;
        mv_nx     = 1'b0;
        to_nx     = timeout;
        lock_nx   = lock_cnt;
        if (!en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            to_nx    = 1'b0;
            lock_nx  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = ARM;
                    cnt_nx   = '0;
                end
                ARM: begin
                    if (rise) begin
                        state_nx = HIGH;
                        cnt_nx   = '0;
                    end else if (at_max) begin
                        to_nx   = 1'b1;
                        lock_nx = '0;
                        cnt_nx  = '0;
                    end
                end
                HIGH: begin
                    if (rise) begin
                        // fall was missed: restart the period, drop lock progress
                        cnt_nx  = '0;
                        lock_nx = '0;
                    end else if (at_max) begin
                        state_nx = ARM;
                        to_nx    = 1'b1;
                        lock_nx  = '0;
                        cnt_nx   = '0;
                    end else if (fall) begin
                        state_nx = LOW;
                        hcap_nx  = cnt + CNT_W'(1);
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_nx  = HIGH;
                        period_nx = cnt + CNT_W'(1);
                        high_nx   = hcap;
                        mv_nx     = 1'b1;
                        to_nx     = 1'b0;
                        cnt_nx    = '0;
                        lock_nx   = locked ? lock_cnt : lock_cnt + LW'(1);
                    end else if (at_max) begin
                        state_nx = ARM;
                        to_nx    = 1'b1;
                        lock_nx  = '0;
                        cnt_nx   = '0;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_f0_pulse_meter.sv
// tb_f0_pulse_meter: randomized self-checking bench for f0_pulse_meter
module tb_f0_pulse_meter;
    localparam int CNT_W  = 20;
    localparam int MAXP   = 400;
    localparam int LOCK_N = 2;

    typedef struct packed {
        logic [CNT_W-1:0] h;
        logic [CNT_W-1:0] p;
        logic             lk;
    } meas_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             f0 = 1'b0;
    logic             en = 1'b0;
    logic [CNT_W-1:0] high_cnt, period_cnt;
    logic             meas_valid, timeout, locked;

    f0_pulse_meter #(.CNT_W(CNT_W), .MAX_PERIOD(MAXP), .LOCK_N(LOCK_N)) dut (
        .clk(clk), .rst_n(rst_n), .f0(f0), .en(en),
        .high_cnt(high_cnt), .period_cnt(period_cnt),
        .meas_valid(meas_valid), .timeout(timeout), .locked(locked)
    );

    always #10 clk = ~clk;

    int    tcyc = 0;
    int    n_cmp = 0, n_bad = 0;
    int    n_mv = 0, last_mv_cyc = 0, to_cyc = -1;
    bit    to_prev = 1'b0;
    meas_t exp_q[$], got_q[$];
    meas_t g, e;

    // reference model: pin-level rise/fall times, cycles counted by tcyc
    bit    started = 1'b0;
    int    t_start = 0, t_fall = 0, consec = 0;
    int    last_h = 0, last_p = 0;

    always @(posedge clk) tcyc++;

    always @(negedge clk) begin
        if (meas_valid) begin
            got_q.push_back('{h: high_cnt, p: period_cnt, lk: locked});
            n_mv++;
            last_mv_cyc = tcyc;
        end
        if (timeout && !to_prev) to_cyc = tcyc;
        to_prev = timeout;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // A rise closes the running period unless more than MAXP cycles passed
    // (the meter timed out and re-armed, so this rise only starts a period).
    task automatic model_rise();
        if (started) begin
            if (tcyc - t_start > MAXP) begin
                consec = 0;
            end else begin
                if (consec < LOCK_N) consec++;
                last_h = t_fall - t_start;
                last_p = tcyc - t_start;
                exp_q.push_back('{h: CNT_W'(last_h), p: CNT_W'(last_p), lk: consec == LOCK_N});
            end
        end
        started = 1'b1;
        t_start = tcyc;
    endtask

    task automatic model_stop();
        started = 1'b0;
        consec  = 0;
    endtask

    task automatic pulse(input int h, input int l);
        model_rise();
        f0 = 1'b1;
        tick(h);
        f0 = 1'b0;
        t_fall = tcyc;
        tick(l);
    endtask

    task automatic rand_pulse();
        pulse($urandom_range(8, 120), $urandom_range(8, 150));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        repeat (5) begin
            f0 = ~f0;
            tick(2);
        end
        n_cmp++;
        if ({high_cnt, period_cnt, meas_valid, timeout, locked} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got h=%0d p=%0d mv=%b to=%b lk=%b, want all 0",
                     high_cnt, period_cnt, meas_valid, timeout, locked);
        end
        rst_n = 1'b1;
        tick(2);
        repeat (6) begin
            f0 = 1'b1;
            tick(15);
            f0 = 1'b0;
            tick(25);
        end
        n_cmp++;
        if (n_mv !== 0) begin
            n_bad++;
            $display("FAIL en0_no_strobe: got %0d strobes, want 0", n_mv);
        end
        n_cmp++;
        if ({high_cnt, period_cnt, timeout, locked} !== '0) begin
            n_bad++;
            $display("FAIL en0_outputs: got h=%0d p=%0d to=%b lk=%b, want all 0",
                     high_cnt, period_cnt, timeout, locked);
        end
    endtask

    task automatic test_steady();
        en = 1'b1;
        tick(5);
        repeat (5) pulse(60, 140);
        tick(6);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL steady_count: got %0d strobes, want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL steady_meas: got h=%0d p=%0d lk=%b, want h=%0d p=%0d lk=%b",
                         g.h, g.p, g.lk, e.h, e.p, e.lk);
            end
        end
        got_q.delete();
        exp_q.delete();
        n_cmp++;
        if (locked !== 1'b1 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL steady_flags: got lk=%b to=%b, want lk=1 to=0", locked, timeout);
        end
    endtask

    task automatic test_duty();
        int h;
        repeat (8) begin
            h = $urandom_range(10, 190);
            pulse(h, 200 - h);
        end
        repeat (12) rand_pulse();
        tick(6);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL duty_count: got %0d strobes, want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL duty_meas: got h=%0d p=%0d lk=%b, want h=%0d p=%0d lk=%b",
                         g.h, g.p, g.lk, e.h, e.p, e.lk);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_boundary();
        pulse(100, MAXP - 100);
        pulse(100, MAXP - 99);
        pulse(50, 100);
        n_cmp++;
        if (timeout !== 1'b1 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL over_max_flags: got to=%b lk=%b, want to=1 lk=0", timeout, locked);
        end
        pulse(50, 100);
        pulse(50, 100);
        tick(6);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL boundary_count: got %0d strobes, want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL boundary_meas: got h=%0d p=%0d lk=%b, want h=%0d p=%0d lk=%b",
                         g.h, g.p, g.lk, e.h, e.p, e.lk);
            end
        end
        got_q.delete();
        exp_q.delete();
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL boundary_to_clear: got to=%b, want 0", timeout);
        end
    endtask

    task automatic test_timeout();
        repeat (3) rand_pulse();
        model_rise();
        f0 = 1'b1;
        tick(40);
        f0 = 1'b0;
        to_cyc = -1;
        for (int i = 0; i < MAXP + 40 && to_cyc < 0; i++) tick(1);
        n_cmp++;
        if (to_cyc < 0) begin
            n_bad++;
            $display("FAIL timeout_delay: got no timeout within %0d cycles, want %0d", MAXP + 40, MAXP);
        end else if (to_cyc - last_mv_cyc !== MAXP) begin
            n_bad++;
            $display("FAIL timeout_delay: got %0d cycles, want %0d", to_cyc - last_mv_cyc, MAXP);
        end
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_lock: got lk=%b, want 0", locked);
        end
        tick(5);
        repeat (4) rand_pulse();
        tick(6);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL timeout_count: got %0d strobes, want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL timeout_meas: got h=%0d p=%0d lk=%b, want h=%0d p=%0d lk=%b",
                         g.h, g.p, g.lk, e.h, e.p, e.lk);
            end
        end
        got_q.delete();
        exp_q.delete();
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_clear: got to=%b, want 0", timeout);
        end
    endtask

    task automatic test_enable();
        repeat (3) rand_pulse();
        model_rise();
        f0 = 1'b1;
        tick(20);
        en = 1'b0;
        model_stop();
        tick(10);
        f0 = 1'b0;
        tick(30);
        n_cmp++;
        if (locked !== 1'b0 || timeout !== 1'b0 || high_cnt !== CNT_W'(last_h) || period_cnt !== CNT_W'(last_p)) begin
            n_bad++;
            $display("FAIL en_drop_hold: got lk=%b to=%b h=%0d p=%0d, want lk=0 to=0 h=%0d p=%0d",
                     locked, timeout, high_cnt, period_cnt, last_h, last_p);
        end
        en = 1'b1;
        tick(10);
        repeat (4) rand_pulse();
        tick(6);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL enable_count: got %0d strobes, want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL enable_meas: got h=%0d p=%0d lk=%b, want h=%0d p=%0d lk=%b",
                         g.h, g.p, g.lk, e.h, e.p, e.lk);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_async_reset();
        repeat (3) rand_pulse();
        model_rise();
        f0 = 1'b1;
        tick(30);
        f0 = 1'b0;
        tick(40);
        #4 rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({high_cnt, period_cnt, meas_valid, timeout, locked} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got h=%0d p=%0d mv=%b to=%b lk=%b, want all 0",
                     high_cnt, period_cnt, meas_valid, timeout, locked);
        end
        model_stop();
        tick(3);
        #3 rst_n = 1'b1;
        tick(5);
        pulse(70, 90);
        model_rise();
        f0 = 1'b1;
        tick(30);
        #3 f0 = 1'b0;
        #8 f0 = 1'b1;
        tick(30);
        f0 = 1'b0;
        t_fall = tcyc;
        tick(100);
        repeat (2) rand_pulse();
        tick(6);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL reset_glitch_count: got %0d strobes, want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL reset_glitch_meas: got h=%0d p=%0d lk=%b, want h=%0d p=%0d lk=%b",
                         g.h, g.p, g.lk, e.h, e.p, e.lk);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        tick(1);
        test_reset();
        test_steady();
        test_duty();
        test_boundary();
        test_timeout();
        test_enable();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
